// File: rtl/uart_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and watchdog sizing.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LAUNCH      = 3'd1,
        S_WAIT_ACTIVE = 3'd2,
        S_WAIT_DONE   = 3'd3,
        S_RELEASE     = 3'd4
    } sched_state_t;

    // One spare bit lets the counter reach START_TIMEOUT-1 without ever wrapping.
    function automatic int wd_cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

    localparam int START_TIMEOUT_DEF = 16;
    localparam int WD_CNT_W          = wd_cnt_width(START_TIMEOUT_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first eligible index above last_grant, with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_eligible,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        int idx;
        idx          = 0;
        any_eligible = 1'b0;
        grant_idx    = '0;
        // Scan farthest offset first so the nearest eligible one is assigned last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (eligible[idx]) begin
                any_eligible = 1'b1;
                grant_idx    = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte sources, round-robin; tx_send 1 cycle after valid seen in IDLE.
// Backpressure: req_ready only pulses in LAUNCH; sources hold valid/data until then; the channel is busy until done or start timeout.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  DATA_W        = 8,
    parameter int  START_TIMEOUT = 16,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                        baud_clk_w,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_enable,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        tx_active_flag,
    input  logic                        tx_done_flag,
    output logic                        tx_send,
    output logic [DATA_W-1:0]           tx_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic                        tx_complete,
    output logic                        timeout_err
);

    localparam int CNT_W = wd_cnt_width(START_TIMEOUT);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  pick;
    logic             any_elig;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;

    assign wd_expired = (wd_cnt >= CNT_W'(START_TIMEOUT - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .eligible     (req_valid & req_enable),
        .last_grant   (last_grant),
        .any_eligible (any_elig),
        .grant_idx    (pick)
    );

    always_ff @(posedge baud_clk_w or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_elig) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                // A done left over from the previous frame is deliberately ignored here.
                if (tx_active_flag) begin
                    state_nxt = S_WAIT_DONE;
                end else if (wd_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done_flag && !tx_active_flag) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_send     = 1'b0;
        req_ready   = '0;
        busy        = (state != S_IDLE);
        tx_complete = 1'b0;
        timeout_err = 1'b0;
        case (state)
            S_LAUNCH: begin
                tx_send   = 1'b1;
                req_ready = NUM_REQ'(1) << grant_id;
            end
            S_WAIT_ACTIVE: begin
                timeout_err = !tx_active_flag && wd_expired;
            end
            S_RELEASE: begin
                tx_complete = 1'b1;
            end
            default: begin
                tx_send = 1'b0;
            end
        endcase
    end

    always_ff @(posedge baud_clk_w or negedge reset_n) begin
        if (!reset_n) begin
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            wd_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_elig) begin
                        tx_data  <= req_data[int'(pick)*DATA_W +: DATA_W];
                        grant_id <= pick;
                    end
                end
                S_LAUNCH: begin
                    wd_cnt <= '0;
                end
                S_WAIT_ACTIVE: begin
                    if (!tx_active_flag) begin
                        if (wd_expired) begin
                            last_grant <= grant_id;
                        end else begin
                            wd_cnt <= wd_cnt + CNT_W'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    last_grant <= grant_id;
                end
                default: begin
                    wd_cnt <= wd_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: rotation, masking, start timeout, stale done and async reset.
module tb_uart_tx_scheduler;

    logic        baud_clk_w = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_enable;
    logic [3:0]  req_ready;
    logic        tx_active_flag;
    logic        tx_done_flag;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_complete;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    uart_tx_scheduler #(
        .NUM_REQ       (4),
        .DATA_W        (8),
        .START_TIMEOUT (16)
    ) dut (
        .baud_clk_w     (baud_clk_w),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_enable     (req_enable),
        .req_ready      (req_ready),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag),
        .tx_send        (tx_send),
        .tx_data        (tx_data),
        .grant_id       (grant_id),
        .busy           (busy),
        .tx_complete    (tx_complete),
        .timeout_err    (timeout_err)
    );

    always #5 baud_clk_w = ~baud_clk_w;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge baud_clk_w);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Starts in IDLE with the expected requester eligible; ends in IDLE after RELEASE.
    task automatic do_frame(input logic [1:0] gid, input logic [7:0] dat);
        logic [3:0] ready_exp;
        ready_exp = 4'b0001 << gid;
        tick();
        chk("launch_send", 32'(tx_send), 32'd1);
        chk("launch_grant", 32'(grant_id), 32'(gid));
        chk("launch_data", 32'(tx_data), 32'(dat));
        chk("launch_ready", 32'(req_ready), 32'(ready_exp));
        tick();
        chk("wait_send_low", 32'(tx_send), 32'd0);
        tx_active_flag = 1'b1;
        tx_done_flag   = 1'b0;
        tick();
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b1;
        tick();
        chk("release_complete", 32'(tx_complete), 32'd1);
        tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        req_valid      = '0;
        req_data       = '0;
        req_enable     = '0;
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_send", 32'(tx_send), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_complete", 32'(tx_complete), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // single requester 2
        req_valid  = 4'b0100;
        req_data   = 32'h00A5_0000;
        req_enable = 4'hF;
        do_frame(2'd2, 8'hA5);
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_complete", 32'(tx_complete), 32'd0);
        req_valid = '0;

        // all valid, full rotation from reset
        apply_reset();
        req_valid = 4'hF;
        req_data  = 32'h1312_1110;
        do_frame(2'd0, 8'h10);
        do_frame(2'd1, 8'h11);
        do_frame(2'd2, 8'h12);
        do_frame(2'd3, 8'h13);
        do_frame(2'd0, 8'h10);
        req_valid = '0;

        // requester 1 masked off
        apply_reset();
        req_valid  = 4'hF;
        req_enable = 4'b1101;
        do_frame(2'd0, 8'h10);
        do_frame(2'd2, 8'h12);
        do_frame(2'd3, 8'h13);
        do_frame(2'd0, 8'h10);
        req_valid  = '0;
        req_enable = 4'hF;

        // start watchdog: transmitter never goes active
        apply_reset();
        tx_done_flag = 1'b0;
        req_valid    = 4'b0010;
        req_data     = 32'h3322_5A11;
        tick();
        chk("to_launch_grant", 32'(grant_id), 32'd1);
        chk("to_launch_data", 32'(tx_data), 32'h5A);
        req_valid = '0;
        repeat (15) tick();
        chk("to_early_timeout", 32'(timeout_err), 32'd0);
        chk("to_early_busy", 32'(busy), 32'd1);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        tick();
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_idle_pulse_gone", 32'(timeout_err), 32'd0);
        req_valid = 4'hF;
        tick();
        chk("to_next_send", 32'(tx_send), 32'd1);
        chk("to_next_grant", 32'(grant_id), 32'd2);
        chk("to_next_data", 32'(tx_data), 32'h22);

        // stale done while waiting for active
        req_valid      = '0;
        tx_done_flag   = 1'b1;
        tx_active_flag = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_no_complete", 32'(tx_complete), 32'd0);
        end
        tx_active_flag = 1'b1;
        tick();
        chk("both_high_no_complete_a", 32'(tx_complete), 32'd0);
        tick();
        chk("both_high_no_complete_b", 32'(tx_complete), 32'd0);
        tx_active_flag = 1'b0;
        tick();
        chk("stale_release", 32'(tx_complete), 32'd1);
        tick();
        chk("stale_idle_busy", 32'(busy), 32'd0);

        // async reset in WAIT_DONE
        req_valid    = 4'b1000;
        req_data     = 32'h4400_0000;
        tx_done_flag = 1'b0;
        tick();
        chk("rw_launch_grant", 32'(grant_id), 32'd3);
        req_valid      = '0;
        tx_active_flag = 1'b1;
        tick();
        tick();
        chk("rw_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rw_async_busy", 32'(busy), 32'd0);
        chk("rw_async_grant", 32'(grant_id), 32'd0);
        chk("rw_async_data", 32'(tx_data), 32'd0);
        chk("rw_async_send", 32'(tx_send), 32'd0);
        chk("rw_async_ready", 32'(req_ready), 32'd0);
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b1;
        tick();
        chk("rw_no_complete", 32'(tx_complete), 32'd0);
        reset_n   = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h0000_0077;
        tick();
        chk("rw_first_grant", 32'(grant_id), 32'd0);
        chk("rw_first_data", 32'(tx_data), 32'h77);
        chk("rw_first_send", 32'(tx_send), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter between up to NUM_REQ byte sources. It runs on the transmitter's baud clock, accepts one byte at a time from a granted requester over a valid/ready handshake, issues the transmitter's send pulse, and tracks the active/done flags to completion. A start watchdog recovers the channel if the transmitter never goes active. It replaces ad-hoc FIFO-read sequencing in front of the Tx unit.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 8: byte width
- START_TIMEOUT, 16: baud cycles allowed between send and tx_active_flag
- baud_clk_w  in  1  transmitter baud clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
- req_enable  in  NUM_REQ  arbitration mask; 0 = never granted
- req_ready  out  NUM_REQ  one-hot accept strobe
- tx_active_flag  in  1  transmitter busy
- tx_done_flag  in  1  transmitter frame finished
- tx_send  out  1  one-cycle send strobe to transmitter
- tx_data  out  DATA_W  byte presented to transmitter, held until next grant
- grant_id  out  $clog2(NUM_REQ)  requester owning the current or last transfer
- busy  out  1  high in any state except IDLE
- tx_complete  out  1  one-cycle pulse when a frame finishes
- timeout_err  out  1  one-cycle pulse on start-watchdog expiry

## Operation
- States: IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, RELEASE.
- IDLE: eligible = req_valid & req_enable. If eligible is nonzero, choose g, the first eligible index searching upward from last_grant+1 with wrap. At that edge, latch tx_data <= req_data[g] and grant_id <= g, then go to LAUNCH. If eligible is zero, stay in IDLE.
- LAUNCH, one cycle only: tx_send = 1 and req_ready[grant_id] = 1. Both are decoded from the state and are otherwise 0. The requester must hold valid and data stable from assertion until it sees ready. Transfer completes at the LAUNCH exit edge. Clear the watchdog counter, then go to WAIT_ACTIVE.
- WAIT_ACTIVE: if tx_active_flag, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches START_TIMEOUT-1 without active, pulse timeout_err, update last_grant <= grant_id, and return to IDLE. The byte is dropped and not retried.
- WAIT_DONE: when tx_done_flag=1 and tx_active_flag=0, go to RELEASE. There is no timeout in this state.
- RELEASE, one cycle: tx_complete = 1, last_grant <= grant_id, then go to IDLE.
- Watchdog counter width is $clog2(START_TIMEOUT)+1 and saturates. It never wraps.
- Changing req_enable or dropping req_valid after the grant does not abort the transfer in flight.

## Timing
- Reset values: state IDLE, last_grant NUM_REQ-1 (so requester 0 wins first), tx_data 0, grant_id 0, counter 0. All strobes are 0 and busy is 0.
- Reset mid-transfer returns to IDLE immediately. No tx_complete or timeout_err is emitted.
- Latency from valid sampled in IDLE to tx_send is 1 cycle. req_ready is coincident with tx_send.
- Minimum period per byte: IDLE, LAUNCH, WAIT_ACTIVE (≥1 cycle), WAIT_DONE (≥1 cycle), RELEASE. That is 5 cycles plus transmitter time.
- tx_active_flag and tx_done_flag are sampled only on baud_clk_w. The transmitter holds done until its next send.
- Stale done: if done is still high from the previous frame while in WAIT_ACTIVE, it is ignored. Only active advances the state there.
- If active and done are both high in WAIT_DONE, stay in WAIT_DONE.
- If all requesters are valid continuously, grants rotate 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 transfers.

## Structure
- Package uart_sched_pkg holds:
  - the state enum sched_state_t (logic [2:0]);
  - the localparam for the watchdog counter width.
- Sub-module rr_arbiter (NUM_REQ) provides the purely combinational pick:
  - inputs: eligible vector and last_grant;
  - outputs: any-eligible flag and grant index.
- The FSM, latches and watchdog live in uart_tx_scheduler.

## Test plan
- Single requester: req_valid[2]=1, req_data=0xA5, enable=4'hF. Expect tx_send and req_ready=4'b0100 one cycle after, and tx_data=0xA5 and grant_id=2. After active then done, expect a tx_complete pulse and busy=0 the next cycle.
- All four valid continuously with bytes 0x10..0x13. Expect grant order 0,1,2,3,0 and one tx_send per completed frame.
- req_enable=4'b1101 with all valid. Expect requester 1 never granted and order 0,2,3,0.
- tx_active_flag held 0 after send, with START_TIMEOUT=16. Expect a timeout_err pulse 16 cycles after LAUNCH and return to IDLE. The next grant goes to grant_id+1.
- Stale tx_done_flag=1 during WAIT_ACTIVE. Expect no advance until active, then RELEASE only after done=1 and active=0.
- reset_n asserted in WAIT_DONE. Expect all outputs at reset values asynchronously, no tx_complete, and the first post-reset grant to requester 0.
